// File: rtl/audio_seq_pkg.sv
// Shared types for the note sequencer and the blocks built around it.
package audio_seq_pkg;

  localparam int FREQ_W = 16;
  localparam int DUR_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PLAY,
    GAP
  } seq_state_e;

  // One pattern entry: generator phase increment and note length in ticks.
  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [DUR_W-1:0]  dur;
  } step_t;

endpackage

// File: rtl/audio_tick_prescaler.sv
// Divides clk_i into one-cycle ticks every TICK_DIV enabled cycles.
// Shared by the sequencer and the envelope blocks.
module audio_tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_LAST);
  assign tick_o = en_i & w_wrap;

  // Free-running count 0..TICK_DIV-1 while enabled; clear wins over enable.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/audio_note_sequencer.sv
// Plays a programmed pattern of {freq, duration} steps into a wave generator,
// with a silent gap after each note and optional looping.
module audio_note_sequencer
  import audio_seq_pkg::*;
#(
  parameter  int STEPS     = 16,
  parameter  int TICK_DIV  = 50000,
  parameter  int GAP_TICKS = 2,
  localparam int ADDR_W    = $clog2(STEPS)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [FREQ_W-1:0] wr_freq_i,
  input  logic [DUR_W-1:0]  wr_dur_i,
  output logic              wr_ready_o,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_i,
  input  logic [ADDR_W:0]   len_i,
  output logic [FREQ_W-1:0] freq_o,
  output logic              gate_o,
  output logic [ADDR_W-1:0] step_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W:0]  STEPS_L  = (ADDR_W + 1)'(STEPS);
  localparam logic [ADDR_W:0]  ONE_L    = (ADDR_W + 1)'(1);
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  seq_state_e        r_state;
  step_t             r_mem [STEPS];
  logic [FREQ_W-1:0] r_freq;
  logic              r_gate;
  logic [ADDR_W-1:0] r_step;
  logic [ADDR_W-1:0] r_last;
  logic [DUR_W-1:0]  r_dur;
  logic [DUR_W-1:0]  r_tick_cnt;
  logic              r_busy;
  logic              r_done;

  step_t             w_rd;
  logic              w_tick;
  logic              w_addr_ok;
  logic              w_wr_accept;
  logic [ADDR_W:0]   w_len_clamp;
  logic [ADDR_W:0]   w_len_m1;
  logic              w_play_done;
  logic              w_gap_done;
  logic              w_advance;

  assign w_rd        = r_mem[r_step];
  assign w_addr_ok   = ({1'b0, wr_addr_i} < STEPS_L);
  assign w_wr_accept = wr_en_i & ~r_busy & w_addr_ok;
  assign w_len_clamp = (len_i > STEPS_L) ? STEPS_L : len_i;
  assign w_len_m1    = w_len_clamp - ONE_L;

  assign w_play_done = (r_state == PLAY) & w_tick & (r_tick_cnt == r_dur - DUR_W'(1));
  assign w_gap_done  = (r_state == GAP) & w_tick & (r_tick_cnt == GAP_LAST);
  // With no gap configured the note end advances directly.
  assign w_advance   = (GAP_TICKS == 0) ? w_play_done : w_gap_done;

  audio_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  ((r_state == IDLE) || (r_state == FETCH)),
    .en_i   ((r_state == PLAY) || (r_state == GAP)),
    .tick_o (w_tick)
  );

  // Pattern memory write port, open only while idle.
  // NOTE: no reset on the memory array so a reset never erases the programmed pattern.
  always_ff @(posedge clk_i) begin
    if (w_wr_accept) begin
      r_mem[wr_addr_i] <= '{freq: wr_freq_i, dur: wr_dur_i};
    end
  end

  // Playback FSM with all outputs registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state    <= IDLE;
      r_freq     <= '0;
      r_gate     <= 1'b0;
      r_step     <= '0;
      r_last     <= '0;
      r_dur      <= '0;
      r_tick_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != IDLE) && stop_i) begin
        // Abort: silence immediately, no completion pulse.
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_freq  <= '0;
        r_gate  <= 1'b0;
        r_step  <= '0;
      end else if (w_advance) begin
        r_gate     <= 1'b0;
        r_tick_cnt <= '0;
        if (r_step != r_last) begin
          r_step  <= r_step + ADDR_W'(1);
          r_state <= FETCH;
        end else if (loop_i) begin
          r_step  <= '0;
          r_state <= FETCH;
        end else begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_freq  <= '0;
          r_step  <= '0;
          r_done  <= 1'b1;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (start_i && !stop_i && (len_i != '0)) begin
              r_state <= FETCH;
              r_busy  <= 1'b1;
              r_step  <= '0;
              r_last  <= w_len_m1[ADDR_W-1:0];
            end
          end
          FETCH: begin
            if (w_rd.dur == '0) begin
              // End-of-pattern marker ends playback like a natural finish.
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_freq  <= '0;
              r_gate  <= 1'b0;
              r_step  <= '0;
              r_done  <= 1'b1;
            end else begin
              r_state    <= PLAY;
              r_freq     <= w_rd.freq;
              r_gate     <= 1'b1;
              r_dur      <= w_rd.dur;
              r_tick_cnt <= '0;
            end
          end
          PLAY: begin
            if (w_play_done) begin
              // Release tail: gate drops, frequency held through the gap.
              r_state    <= GAP;
              r_gate     <= 1'b0;
              r_tick_cnt <= '0;
            end else if (w_tick) begin
              r_tick_cnt <= r_tick_cnt + DUR_W'(1);
            end
          end
          GAP: begin
            if (w_tick) begin
              r_tick_cnt <= r_tick_cnt + DUR_W'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign freq_o     = r_freq;
  assign gate_o     = r_gate;
  assign step_o     = r_step;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign wr_ready_o = ~r_busy;

endmodule

// File: tb/tb_audio_note_sequencer.sv
// Self-checking bench for audio_note_sequencer: directed scenarios plus random
// patterns, compared cycle by cycle against a step-level playback model.
module tb_audio_note_sequencer;

  localparam int STEPS     = 16;
  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 1;
  localparam int ADDR_W    = 4;

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              wr_en_i = 1'b0;
  logic [ADDR_W-1:0] wr_addr_i = '0;
  logic [15:0]       wr_freq_i = '0;
  logic [7:0]        wr_dur_i = '0;
  logic              wr_ready_o;
  logic              start_i = 1'b0;
  logic              stop_i = 1'b0;
  logic              loop_i = 1'b0;
  logic [ADDR_W:0]   len_i = '0;
  logic [15:0]       freq_o;
  logic              gate_o;
  logic [ADDR_W-1:0] step_o;
  logic              busy_o;
  logic              done_o;

  audio_note_sequencer #(
    .STEPS     (STEPS),
    .TICK_DIV  (TICK_DIV),
    .GAP_TICKS (GAP_TICKS)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_freq_i  (wr_freq_i),
    .wr_dur_i   (wr_dur_i),
    .wr_ready_o (wr_ready_o),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .loop_i     (loop_i),
    .len_i      (len_i),
    .freq_o     (freq_o),
    .gate_o     (gate_o),
    .step_o     (step_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic              busy;
    logic              gate;
    logic              done;
    logic [ADDR_W-1:0] step;
    logic [15:0]       freq;
  } obs_t;

  obs_t obs;
  assign obs = {busy_o, gate_o, done_o, step_o, freq_o};

  // Reference pattern memory and expected per-cycle trace.
  logic [15:0] m_freq [STEPS];
  logic [7:0]  m_dur  [STEPS];
  obs_t        exp_q  [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Step index is only meaningful while playing.
  task automatic check_obs(input string tag, input obs_t o, input obs_t e);
    obs_t om;
    obs_t em;
    om = o;
    em = e;
    if (!e.busy) begin
      om.step = '0;
      em.step = '0;
    end
    check(tag, 32'(om), 32'(em));
  endtask

  function automatic obs_t mk(input logic busy, input logic gate, input logic done,
                              input int step, input logic [15:0] freq);
    obs_t o;
    o.busy = busy;
    o.gate = gate;
    o.done = done;
    o.step = ADDR_W'(step);
    o.freq = freq;
    return o;
  endfunction

  // Expected outputs for every cycle after the start edge, derived from the
  // playback rules: 1 fetch cycle, dur*TICK_DIV gated cycles, gap cycles, advance.
  task automatic build_trace(input int len, input bit loop, input int cap);
    int          n;
    int          s;
    logic [15:0] f;
    n = (len > STEPS) ? STEPS : len;
    s = 0;
    f = 16'h0;
    exp_q.delete();
    while (exp_q.size() < cap) begin
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, s, f));
      if (m_dur[s] == 8'd0) begin
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 0, 16'h0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 0, 16'h0));
        break;
      end
      f = m_freq[s];
      repeat (int'(m_dur[s]) * TICK_DIV) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, s, f));
      repeat (GAP_TICKS * TICK_DIV) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, s, f));
      if (s < n - 1) begin
        s++;
      end else if (loop) begin
        s = 0;
      end else begin
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 0, 16'h0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 0, 16'h0));
        break;
      end
    end
    while (exp_q.size() > cap) void'(exp_q.pop_back());
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_step(input int addr, input logic [15:0] f, input logic [7:0] d);
    wr_en_i   = 1'b1;
    wr_addr_i = ADDR_W'(addr);
    wr_freq_i = f;
    wr_dur_i  = d;
    tick();
    wr_en_i   = 1'b0;
    m_freq[addr] = f;
    m_dur[addr]  = d;
  endtask

  // Start playback and compare against the model trace cycle by cycle.
  task automatic run(input string name, input int len, input bit loop, input int cap);
    build_trace(len, loop, cap);
    len_i   = (ADDR_W + 1)'(len);
    loop_i  = loop;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wr_en_i = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i != 0) tick();
      check_obs($sformatf("%s[%0d]", name, i), obs, exp_q[i]);
    end
  endtask

  initial begin
    logic [15:0] nf;

    // Reset state.
    rstn_i = 1'b0;
    tick();
    tick();
    check("reset_outputs", 32'(obs), 32'h0);
    check("reset_wr_ready", 32'(wr_ready_o), 32'h1);
    rstn_i = 1'b1;
    tick();

    // Two-note pattern, no loop.
    write_step(0, 16'h0100, 8'd3);
    write_step(1, 16'h0200, 8'd2);
    run("two_note", 2, 1'b0, 1000);
    tick();

    // Reset mid-play aborts at once; memory survives.
    len_i   = 5'd2;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    check("midplay_gate", 32'(gate_o), 32'h1);
    rstn_i = 1'b0;
    tick();
    check("midplay_reset", 32'(obs), 32'h0);
    rstn_i = 1'b1;
    tick();
    run("after_reset", 2, 1'b0, 1000);
    tick();

    // Looping: one full round plus re-fetch of step 0, then stop mid-PLAY.
    run("loop", 2, 1'b1, 34);
    check("loop_gate_before_stop", 32'(gate_o), 32'h1);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check("loop_stop", 32'(obs), 32'h0);
    tick();
    check("loop_after_stop", 32'(obs), 32'h0);
    loop_i = 1'b0;

    // End-of-pattern marker in step 1.
    write_step(1, 16'h0200, 8'd0);
    run("marker", 4, 1'b0, 1000);
    tick();

    // Writes while busy are dropped.
    nf = 16'($urandom_range(1, 16'hFFFE));
    write_step(0, nf, 8'd5);
    len_i   = 5'd1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    check("busy_wr_ready", 32'(wr_ready_o), 32'h0);
    wr_en_i   = 1'b1;
    wr_addr_i = '0;
    wr_freq_i = 16'hFFFF;
    wr_dur_i  = 8'd1;
    tick();
    wr_en_i = 1'b0;
    stop_i  = 1'b1;
    tick();
    stop_i  = 1'b0;
    check("busy_stop", 32'(busy_o), 32'h0);
    tick();
    run("dropped_write", 1, 1'b0, 1000);
    tick();

    // Write and start in the same cycle: the fetch sees the new data.
    nf = 16'($urandom_range(1, 16'hFFFE));
    wr_en_i   = 1'b1;
    wr_addr_i = '0;
    wr_freq_i = nf;
    wr_dur_i  = 8'd2;
    m_freq[0] = nf;
    m_dur[0]  = 8'd2;
    run("write_and_start", 1, 1'b0, 1000);
    tick();

    // len 0 and start+stop both leave the sequencer idle.
    len_i   = '0;
    start_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("len0_busy[%0d]", i), 32'(busy_o), 32'h0);
    end
    len_i  = 5'd2;
    stop_i = 1'b1;
    tick();
    check("start_stop_busy", 32'(busy_o), 32'h0);
    tick();
    check("start_stop_busy2", 32'(busy_o), 32'h0);
    start_i = 1'b0;
    stop_i  = 1'b0;
    tick();

    // len 20 clamps to the full 16-step pattern.
    for (int i = 0; i < STEPS; i++) begin
      write_step(i, 16'($urandom_range(1, 16'hFFFF)), 8'($urandom_range(1, 2)));
    end
    run("len_clamp", 20, 1'b0, 4000);
    tick();

    // Random patterns, occasionally with an early end marker.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < STEPS; i++) begin
        write_step(i, 16'($urandom_range(0, 16'hFFFF)),
                   ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 3)));
      end
      run($sformatf("random%0d", r), int'($urandom_range(1, STEPS)), 1'b0, 4000);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
